// File: rtl/grf_regfile.sv
// General register file for the single-cycle MIPS datapath: two combinational read ports, one write port, $0 hardwired to zero.
// Optional same-cycle write-to-read forwarding is enabled by defining GRF_WRITE_BYPASS_EN.
module grf_regfile #(
    parameter int DW = 32,
    parameter int AW = 5
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [AW-1:0] ra1,
    input  logic [AW-1:0] ra2,
    output logic [DW-1:0] rd1,
    output logic [DW-1:0] rd2,
    input  logic          we,
    input  logic [AW-1:0] wa,
    input  logic [DW-1:0] wd,
    input  logic [31:0]   pc
);

    localparam int NREG = 1 << AW;
    localparam logic [AW-1:0] ZERO_ADDR = {AW{1'b0}};
    localparam logic [DW-1:0] ZERO_DATA = {DW{1'b0}};

    logic [DW-1:0] mem_q [NREG];
    logic [DW-1:0] mem_d [NREG];
    logic          wr_en_s;

    // Commit qualifier; an unknown we fails the equality and falls to no-write.
    always_comb begin
        if ((we == 1'b1) && (wa != ZERO_ADDR)) begin
            wr_en_s = 1'b1;
        end else begin
            wr_en_s = 1'b0;
        end
    end

    // Next-state of the array: only the addressed entry changes, entry 0 pinned to zero.
    always_comb begin
        for (int i = 0; i < NREG; i++) begin
            mem_d[i] = mem_q[i];
        end
        if (wr_en_s) begin
            mem_d[wa] = wd;
        end else begin
            mem_d[0] = ZERO_DATA;
        end
        mem_d[0] = ZERO_DATA;
    end

    // Storage flops, cleared asynchronously by reset_n.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NREG; i++) begin
                mem_q[i] <= ZERO_DATA;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    // Read port 1: $0 and reset force zero ahead of any forwarding.
    always_comb begin
        if ((reset_n == 1'b0) || (ra1 == ZERO_ADDR)) begin
            rd1 = ZERO_DATA;
`ifdef GRF_WRITE_BYPASS_EN
        end else if (wr_en_s && (wa == ra1)) begin
            rd1 = wd;
`endif
        end else begin
            rd1 = mem_q[ra1];
        end
    end

    // Read port 2: same selection as port 1.
    always_comb begin
        if ((reset_n == 1'b0) || (ra2 == ZERO_ADDR)) begin
            rd2 = ZERO_DATA;
`ifdef GRF_WRITE_BYPASS_EN
        end else if (wr_en_s && (wa == ra2)) begin
            rd2 = wd;
`endif
        end else begin
            rd2 = mem_q[ra2];
        end
    end

`ifndef SYNTHESIS
    logic [31:0] trace_cnt_q;

    // Simulation-only commit trace for the grading flow, with a running count of lines printed.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            trace_cnt_q <= 32'd0;
        end else if (wr_en_s) begin
            $display("@%h: $%d <= %h", pc, wa, wd);
            trace_cnt_q <= trace_cnt_q + 32'd1;
        end else begin
            trace_cnt_q <= trace_cnt_q;
        end
    end
`endif

endmodule

// File: tb/tb_grf_regfile.sv
// Directed, table-driven bench for grf_regfile with hand-written sequences for reset, collision and full sweep.
module tb_grf_regfile;

    logic        clk;
    logic        reset_n;
    logic [4:0]  ra1, ra2, wa;
    logic [31:0] rd1, rd2, wd, pc;
    logic        we;

    int n_vec;
    int n_miss;

    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [31:0] pc;
        logic [4:0]  ra1;
        logic [4:0]  ra2;
        logic [31:0] exp1;
        logic [31:0] exp2;
        logic [31:0] exp_tr;
    } vec_t;

    vec_t vecs [9];

    grf_regfile #(.DW(32), .AW(5)) dut (
        .clk(clk), .reset_n(reset_n),
        .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
        .we(we), .wa(wa), .wd(wd), .pc(pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] tr_base;
    logic [31:0] e1, e2;

    initial begin
        n_vec = 0;
        n_miss = 0;
        reset_n = 1'b0;
        we = 1'b0; wa = 5'd0; wd = 32'd0; pc = 32'd0; ra1 = 5'd0; ra2 = 5'd0;

        // reset state and no write while reset is held
        #2;
        ra1 = 5'd7; ra2 = 5'd5;
        we = 1'b1; wa = 5'd7; wd = 32'h0000_0077; pc = 32'h0000_1000;
        #1;
        chk("reset_rd1", rd1, 32'h0);
        chk("reset_rd2", rd2, 32'h0);
        tick();
        chk("reset_edge_nowrite", rd1, 32'h0);
        reset_n = 1'b1;
        tick();
        chk("first_write_after_release", rd1, 32'h0000_0077);

        // asynchronous reset pulse mid-cycle clears the file
        wa = 5'd5; wd = 32'hDEAD_BEEF; ra1 = 5'd5;
        tick();
        chk("pre_pulse_5", rd1, 32'hDEAD_BEEF);
        we = 1'b0;
        reset_n = 1'b0;
        #1;
        chk("pulse_low_5", rd1, 32'h0);
        #2;
        reset_n = 1'b1;
        #1;
        chk("pulse_released_5", rd1, 32'h0);
        ra1 = 5'd7;
        chk("pulse_released_7", rd1, 32'h0);
        tick();

        vecs[0] = '{1'b1, 5'd8,  32'h0000_1234, 32'h0000_3000, 5'd8,  5'd0,  32'h0000_1234, 32'h0,         32'd1};
        vecs[1] = '{1'b1, 5'd0,  32'hFFFF_FFFF, 32'h0000_3004, 5'd0,  5'd0,  32'h0,         32'h0,         32'd0};
        vecs[2] = '{1'b1, 5'd9,  32'h0000_0055, 32'h0000_3008, 5'd9,  5'd9,  32'h0000_0055, 32'h0000_0055, 32'd1};
        vecs[3] = '{1'b0, 5'd9,  32'h0000_00AA, 32'h0000_300C, 5'd8,  5'd9,  32'h0000_1234, 32'h0000_0055, 32'd0};
        vecs[4] = '{1'b0, 5'd9,  32'h0000_00AA, 32'h0000_3010, 5'd8,  5'd9,  32'h0000_1234, 32'h0000_0055, 32'd0};
        vecs[5] = '{1'b0, 5'd9,  32'h0000_00AA, 32'h0000_3014, 5'd8,  5'd9,  32'h0000_1234, 32'h0000_0055, 32'd0};
        vecs[6] = '{1'b1, 5'd31, 32'hCAFE_F00D, 32'h0000_3018, 5'd31, 5'd8,  32'hCAFE_F00D, 32'h0000_1234, 32'd1};
        vecs[7] = '{1'b1, 5'd8,  32'h0000_0000, 32'h0000_301C, 5'd8,  5'd31, 32'h0,         32'hCAFE_F00D, 32'd1};
        vecs[8] = '{1'b1, 5'd1,  32'h0000_0001, 32'h0000_3020, 5'd1,  5'd5,  32'h0000_0001, 32'h0,         32'd1};

        for (int k = 0; k < 9; k++) begin
            we = vecs[k].we; wa = vecs[k].wa; wd = vecs[k].wd; pc = vecs[k].pc;
            ra1 = vecs[k].ra1; ra2 = vecs[k].ra2;
`ifndef SYNTHESIS
            tr_base = dut.trace_cnt_q;
`endif
            tick();
            chk($sformatf("vec%0d_rd1", k), rd1, vecs[k].exp1);
            chk($sformatf("vec%0d_rd2", k), rd2, vecs[k].exp2);
`ifndef SYNTHESIS
            chk($sformatf("vec%0d_trace", k), dut.trace_cnt_q - tr_base, vecs[k].exp_tr);
`endif
        end

        // read/write collision on both ports
        we = 1'b1; wa = 5'd3; wd = 32'h0000_0010; ra1 = 5'd0; ra2 = 5'd0;
        tick();
        wd = 32'h0000_0020; ra1 = 5'd3; ra2 = 5'd3;
        #1;
`ifdef GRF_WRITE_BYPASS_EN
        chk("collide_pre_rd1", rd1, 32'h0000_0020);
        chk("collide_pre_rd2", rd2, 32'h0000_0020);
`else
        chk("collide_pre_rd1", rd1, 32'h0000_0010);
        chk("collide_pre_rd2", rd2, 32'h0000_0010);
`endif
        tick();
        chk("collide_post_rd1", rd1, 32'h0000_0020);
        chk("collide_post_rd2", rd2, 32'h0000_0020);

        // write to $0 never forwards, even when read address is 0
        wa = 5'd0; wd = 32'h1234_5678; ra1 = 5'd0; ra2 = 5'd3;
        #1;
        chk("zero_bypass_rd1", rd1, 32'h0);
        chk("zero_bypass_rd2", rd2, 32'h0000_0020);

        // full sweep: write 1..31, then read pairs (i, 31-i)
`ifndef SYNTHESIS
        tr_base = dut.trace_cnt_q;
`endif
        for (int i = 1; i < 32; i++) begin
            we = 1'b1; wa = 5'(i); wd = 32'(i) * 32'h0101_0101; pc = 32'h0000_4000 + 32'(4 * i);
            tick();
        end
        we = 1'b0;
`ifndef SYNTHESIS
        chk("sweep_trace_count", dut.trace_cnt_q - tr_base, 32'd31);
`endif
        for (int i = 0; i < 32; i++) begin
            ra1 = 5'(i); ra2 = 5'(31 - i);
            e1 = 32'(i) * 32'h0101_0101;
            e2 = 32'(31 - i) * 32'h0101_0101;
            #1;
            chk($sformatf("sweep_rd1_%0d", i), rd1, e1);
            chk($sformatf("sweep_rd2_%0d", 31 - i), rd2, e2);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
